// File: rtl/ex_mem_reg.sv
// ex_mem_reg
//   Pipeline register between the execute and memory stages. Captures the
//   ALU result, store data, branch/jump targets and memory/writeback
//   controls, and adds a valid bit. Supports stall (hold), flush (bubble)
//   and a halt drain sequence. Also keeps a sticky error flag and a
//   retired-instruction counter.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   stall                 hold every register this cycle
//   flush                 load a bubble instead of the incoming instruction
//   in_valid              execute stage holds a real instruction
//   *_in / *_out          instruction fields, registered copy on load
//   valid_out             registered instruction is real
//   halted                pipeline has drained after a HALT
//   err_sticky            an error has been registered since reset
//   instr_count           number of valid instructions loaded (wraps)
//
// FSM states
//   state        | meaning
//   ST_RUN       | normal operation, instructions load as they arrive
//   ST_HALT_PEND | HALT just registered; next load is a forced bubble
//   ST_HALTED    | drained; only bubbles load, counter frozen

module ex_mem_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [DATA_W-1:0] branch_tgt_in,
    input  logic [DATA_W-1:0] jump_tgt_in,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [REG_AW-1:0] write_reg_in,
    input  logic              halt_in,
    input  logic              err_in,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [DATA_W-1:0] branch_tgt_out,
    output logic [DATA_W-1:0] jump_tgt_out,
    output logic              mem_write_out,
    output logic              mem_read_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [REG_AW-1:0] write_reg_out,
    output logic              halt_out,
    output logic              err_out,
    output logic              valid_out,
    output logic              halted,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALTED    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   alu_result_q, alu_result_d;
    logic [DATA_W-1:0]   store_data_q, store_data_d;
    logic [DATA_W-1:0]   branch_tgt_q, branch_tgt_d;
    logic [DATA_W-1:0]   jump_tgt_q, jump_tgt_d;
    logic                mem_write_q, mem_write_d;
    logic                mem_read_q, mem_read_d;
    logic                reg_write_q, reg_write_d;
    logic                mem_to_reg_q, mem_to_reg_d;
    logic [REG_AW-1:0]   write_reg_q, write_reg_d;
    logic                halt_q, halt_d;
    logic                err_q, err_d;
    logic                halted_q, halted_d;
    logic                err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]    instr_count_q, instr_count_d;

    always_comb begin
        // Default: hold everything (covers stall).
        state_d       = state_q;
        valid_d       = valid_q;
        alu_result_d  = alu_result_q;
        store_data_d  = store_data_q;
        branch_tgt_d  = branch_tgt_q;
        jump_tgt_d    = jump_tgt_q;
        mem_write_d   = mem_write_q;
        mem_read_d    = mem_read_q;
        reg_write_d   = reg_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        write_reg_d   = write_reg_q;
        halt_d        = halt_q;
        err_d         = err_q;
        halted_d      = halted_q;
        err_sticky_d  = err_sticky_q;
        instr_count_d = instr_count_q;

        if (!stall) begin
            // Every non-stalled edge loads a bubble unless a real
            // instruction is accepted below.
            valid_d      = 1'b0;
            alu_result_d = '0;
            store_data_d = '0;
            branch_tgt_d = '0;
            jump_tgt_d   = '0;
            mem_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            write_reg_d  = '0;
            halt_d       = 1'b0;
            err_d        = 1'b0;

            case (state_q)
                ST_RUN: begin
                    if (in_valid && !flush) begin
                        valid_d       = 1'b1;
                        alu_result_d  = alu_result_in;
                        store_data_d  = store_data_in;
                        branch_tgt_d  = branch_tgt_in;
                        jump_tgt_d    = jump_tgt_in;
                        mem_write_d   = mem_write_in;
                        mem_read_d    = mem_read_in;
                        reg_write_d   = reg_write_in;
                        mem_to_reg_d  = mem_to_reg_in;
                        write_reg_d   = write_reg_in;
                        halt_d        = halt_in;
                        err_d         = err_in;
                        instr_count_d = instr_count_q + CNT_ONE;
                        if (halt_in) begin
                            state_d = ST_HALT_PEND;
                        end
                    end
                end
                ST_HALT_PEND: begin
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end
                ST_HALTED: begin
                    halted_d = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            err_sticky_d = err_sticky_q | err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            valid_q       <= 1'b0;
            alu_result_q  <= '0;
            store_data_q  <= '0;
            branch_tgt_q  <= '0;
            jump_tgt_q    <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            write_reg_q   <= '0;
            halt_q        <= 1'b0;
            err_q         <= 1'b0;
            halted_q      <= 1'b0;
            err_sticky_q  <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            alu_result_q  <= alu_result_d;
            store_data_q  <= store_data_d;
            branch_tgt_q  <= branch_tgt_d;
            jump_tgt_q    <= jump_tgt_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            write_reg_q   <= write_reg_d;
            halt_q        <= halt_d;
            err_q         <= err_d;
            halted_q      <= halted_d;
            err_sticky_q  <= err_sticky_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign valid_out      = valid_q;
    assign alu_result_out = alu_result_q;
    assign store_data_out = store_data_q;
    assign branch_tgt_out = branch_tgt_q;
    assign jump_tgt_out   = jump_tgt_q;
    assign mem_write_out  = mem_write_q;
    assign mem_read_out   = mem_read_q;
    assign reg_write_out  = reg_write_q;
    assign mem_to_reg_out = mem_to_reg_q;
    assign write_reg_out  = write_reg_q;
    assign halt_out       = halt_q;
    assign err_out        = err_q;
    assign halted         = halted_q;
    assign err_sticky     = err_sticky_q;
    assign instr_count    = instr_count_q;

endmodule
